// File: rtl/stall_flush_ctrl.sv
// Pipeline stall/flush controller: Mealy control of pipeline enables and bubbles
// for load-use hazards, taken branches and slow data-memory accesses.
module stall_flush_ctrl #(
   parameter int TIMEOUT      = 255,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        nop_req,
   input  logic        br_taken,
   input  logic        dmem_req,
   input  logic        dmem_ack,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        memwb_bubble,
   output logic        mem_err,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt,
   output logic [1:0]  state
);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_FLUSH    = 2'd1;
   localparam logic [1:0] ST_MEM_WAIT = 2'd2;

   localparam logic [7:0] TIMEOUT_C    = 8'(TIMEOUT);
   localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
   localparam logic       FLUSH_MULTI  = (FLUSH_CYCLES > 1);

   // Control vector: {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble}
   localparam logic [6:0] CTRL_IDLE   = 7'b1111_000;
   localparam logic [6:0] CTRL_NOP    = 7'b0011_010;
   localparam logic [6:0] CTRL_BRANCH = 7'b1111_110;
   localparam logic [6:0] CTRL_FLUSH  = 7'b1111_100;
   localparam logic [6:0] CTRL_FREEZE = 7'b0000_001;
   localparam logic [6:0] CTRL_RESET  = 7'b0000_111;

   logic [1:0]  state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic [1:0]  fctr_q, fctr_d;
   logic        mem_err_q, mem_err_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   logic        mem_stall_s;
   logic [6:0]  ctrl_s;
   logic        br_acc_s;
   logic [6:0]  res_ctrl_s;
   logic [1:0]  res_state_s;
   logic [1:0]  res_fctr_s;
   logic        res_br_s;

   assign mem_stall_s = dmem_req & ~dmem_ack;

   // Branch / load-use resolution used whenever no memory stall is in effect
   always_comb begin
      res_ctrl_s  = CTRL_IDLE;
      res_state_s = ST_RUN;
      res_fctr_s  = 2'd0;
      res_br_s    = 1'b0;
      if (br_taken) begin
         res_ctrl_s = CTRL_BRANCH;
         res_br_s   = 1'b1;
         if (FLUSH_MULTI) begin
            res_state_s = ST_FLUSH;
            res_fctr_s  = FLUSH_RELOAD;
         end else begin
            res_state_s = ST_RUN;
            res_fctr_s  = 2'd0;
         end
      end else if (nop_req) begin
         res_ctrl_s = CTRL_NOP;
      end else begin
         res_ctrl_s = CTRL_IDLE;
      end
   end

   // FSM next state and control outputs
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      fctr_d    = fctr_q;
      mem_err_d = mem_err_q;
      ctrl_s    = CTRL_IDLE;
      br_acc_s  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mem_stall_s) begin
               ctrl_s  = CTRL_FREEZE;
               wait_d  = 8'd1;
               state_d = ST_MEM_WAIT;
            end else begin
               ctrl_s   = res_ctrl_s;
               br_acc_s = res_br_s;
               state_d  = res_state_s;
               fctr_d   = res_fctr_s;
            end
         end
         ST_MEM_WAIT: begin
            if (!dmem_ack && (wait_q < TIMEOUT_C)) begin
               ctrl_s = CTRL_FREEZE;
               wait_d = wait_q + 8'd1;
            end else begin
               // A timed-out access is released as if it had been acknowledged
               if (!dmem_ack) begin
                  mem_err_d = 1'b1;
               end else begin
                  mem_err_d = mem_err_q;
               end
               ctrl_s   = res_ctrl_s;
               br_acc_s = res_br_s;
               state_d  = res_state_s;
               fctr_d   = res_fctr_s;
               wait_d   = 8'd0;
            end
         end
         ST_FLUSH: begin
            if (mem_stall_s) begin
               ctrl_s = CTRL_FREEZE;
            end else if (br_taken) begin
               ctrl_s   = res_ctrl_s;
               br_acc_s = res_br_s;
               state_d  = res_state_s;
               fctr_d   = res_fctr_s;
            end else begin
               ctrl_s = CTRL_FLUSH;
               if (fctr_q <= 2'd1) begin
                  fctr_d  = 2'd0;
                  state_d = ST_RUN;
               end else begin
                  fctr_d  = fctr_q - 2'd1;
                  state_d = ST_FLUSH;
               end
            end
         end
         default: begin
            ctrl_s  = CTRL_IDLE;
            state_d = ST_RUN;
            wait_d  = 8'd0;
            fctr_d  = 2'd0;
         end
      endcase
   end

   // Saturating performance counters
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!ctrl_s[6] && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (br_acc_s && (flush_cnt_q != 16'hFFFF)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         wait_q      <= 8'd0;
         fctr_q      <= 2'd0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         fctr_q      <= fctr_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Reset forces the safe control pattern regardless of the clock
   assign {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble} =
      rst_n ? ctrl_s : CTRL_RESET;

   assign mem_err   = mem_err_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
   assign state     = state_q;

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Directed, table-driven bench for stall_flush_ctrl (TIMEOUT=8, FLUSH_CYCLES=3).
module tb_stall_flush_ctrl;

   localparam logic [6:0] C_IDLE   = 7'b1111_000;
   localparam logic [6:0] C_NOP    = 7'b0011_010;
   localparam logic [6:0] C_BRANCH = 7'b1111_110;
   localparam logic [6:0] C_FLUSH  = 7'b1111_100;
   localparam logic [6:0] C_FREEZE = 7'b0000_001;
   localparam logic [6:0] C_RESET  = 7'b0000_111;

   logic        clk;
   logic        rst_n;
   logic        nop_req, br_taken, dmem_req, dmem_ack;
   logic        pc_en, ifid_en, idex_en, exmem_en;
   logic        ifid_flush, idex_flush, memwb_bubble, mem_err;
   logic [15:0] stall_cnt, flush_cnt;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       nop;
      logic       br;
      logic       dreq;
      logic       dack;
      logic [6:0] exp_ctrl;
      logic [1:0] exp_state;
   } vec_t;

   vec_t vecs [18];

   stall_flush_ctrl #(.TIMEOUT(8), .FLUSH_CYCLES(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .nop_req(nop_req), .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
      .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_ctrl(input string name, input logic [6:0] exp, input logic [1:0] exp_st);
      logic [6:0] act;
      act = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble};
      checks++;
      if (act !== exp || state !== exp_st) begin
         errors++;
         $display("FAIL %s: ctrl=%b state=%0d, expected ctrl=%b state=%0d",
                  name, act, state, exp, exp_st);
      end
   endtask

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock cycle: inputs applied after the rising edge, outputs observed at the falling edge
   task automatic drive(input logic n, input logic b, input logic rq, input logic ak);
      @(posedge clk);
      #1;
      nop_req  = n;
      br_taken = b;
      dmem_req = rq;
      dmem_ack = ak;
      @(negedge clk);
   endtask

   task automatic do_reset(input string name);
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      nop_req  = 1'b1;
      br_taken = 1'b1;
      dmem_req = 1'b1;
      dmem_ack = 1'b0;
      #1;
      check_ctrl({name, "_ctrl"}, C_RESET, 2'd0);
      check16({name, "_stall"}, stall_cnt, 16'd0);
      check16({name, "_flush"}, flush_cnt, 16'd0);
      check16({name, "_err"}, {15'd0, mem_err}, 16'd0);
      @(negedge clk);
      @(negedge clk);
      nop_req  = 1'b0;
      br_taken = 1'b0;
      dmem_req = 1'b0;
      dmem_ack = 1'b0;
      rst_n    = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      nop_req  = 1'b0;
      br_taken = 1'b0;
      dmem_req = 1'b0;
      dmem_ack = 1'b0;

      //            nop   br    dreq  dack  expected  state
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, C_IDLE,   2'd0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, C_NOP,    2'd0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, C_IDLE,   2'd0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, C_BRANCH, 2'd0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, C_FLUSH,  2'd1};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH,  2'd1};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, C_IDLE,   2'd0};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, C_BRANCH, 2'd0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, C_BRANCH, 2'd1};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, C_FREEZE, 2'd1};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, C_FLUSH,  2'd1};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, C_FLUSH,  2'd1};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, C_IDLE,   2'd0};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, C_IDLE,   2'd0};
      vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, C_FREEZE, 2'd0};
      vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, C_FREEZE, 2'd2};
      vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b1, C_NOP,    2'd2};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, C_IDLE,   2'd0};

      do_reset("rst0");
      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].nop, vecs[i].br, vecs[i].dreq, vecs[i].dack);
         check_ctrl($sformatf("vec%0d", i), vecs[i].exp_ctrl, vecs[i].exp_state);
      end
      check16("vec_stall_cnt", stall_cnt, 16'd5);
      check16("vec_flush_cnt", flush_cnt, 16'd3);

      // Single load-use request
      do_reset("rst1");
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check_ctrl("lu_stall", C_NOP, 2'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_ctrl("lu_after", C_IDLE, 2'd0);
      check16("lu_stall_cnt", stall_cnt, 16'd1);

      // Branch with a three-cycle flush window
      do_reset("rst2");
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      check_ctrl("br_c1", C_BRANCH, 2'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_ctrl("br_c2", C_FLUSH, 2'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_ctrl("br_c3", C_FLUSH, 2'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_ctrl("br_c4", C_IDLE, 2'd0);
      check16("br_flush_cnt", flush_cnt, 16'd1);

      // Memory wait of four cycles overlapping a load-use request
      do_reset("rst3");
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0);
         check_ctrl($sformatf("mw_freeze%0d", i), C_FREEZE, (i == 0) ? 2'd0 : 2'd2);
      end
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      check_ctrl("mw_ack", C_NOP, 2'd2);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_ctrl("mw_after", C_IDLE, 2'd0);
      check16("mw_stall_cnt", stall_cnt, 16'd5);

      // Data memory never answers: forced release after TIMEOUT freeze cycles
      do_reset("rst4");
      for (int i = 1; i <= 8; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0);
         check_ctrl($sformatf("to_freeze%0d", i), C_FREEZE, (i == 1) ? 2'd0 : 2'd2);
      end
      check16("to_err_before", {15'd0, mem_err}, 16'd0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      check_ctrl("to_release", C_IDLE, 2'd2);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_ctrl("to_after", C_IDLE, 2'd0);
      check16("to_err_set", {15'd0, mem_err}, 16'd1);
      check16("to_stall_cnt", stall_cnt, 16'd8);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check16("to_err_sticky", {15'd0, mem_err}, 16'd1);

      // Asynchronous reset in the middle of a memory wait
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0);
         check_ctrl($sformatf("ar_freeze%0d", i), C_FREEZE, (i == 0) ? 2'd0 : 2'd2);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_ctrl("ar_ctrl", C_RESET, 2'd0);
      check16("ar_stall", stall_cnt, 16'd0);
      check16("ar_flush", flush_cnt, 16'd0);
      check16("ar_err", {15'd0, mem_err}, 16'd0);
      @(negedge clk);
      dmem_req = 1'b0;
      rst_n    = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_ctrl("ar_first", C_IDLE, 2'd0);

      // Branch held during a memory stall is applied on the ack cycle
      do_reset("rst5");
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      check_ctrl("bm_freeze0", C_FREEZE, 2'd0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      check_ctrl("bm_freeze1", C_FREEZE, 2'd2);
      check16("bm_flush_hold", flush_cnt, 16'd0);
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      check_ctrl("bm_ack", C_BRANCH, 2'd2);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_ctrl("bm_flush", C_FLUSH, 2'd1);
      check16("bm_flush_cnt", flush_cnt, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stall_flush_ctrl.md
STALL_FLUSH_CTRL -- requirements
Module: stall_flush_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of data-memory wait cycles before forced release, range 1..255.
REQ-002 Parameter FLUSH_CYCLES, default 1: number of cycles IF/ID is flushed per taken branch, range 1..3.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 nop_req  input  1  load-use hazard request from forwarding/hazard detection.
REQ-006 br_taken  input  1  taken branch or jump resolved in EX.
REQ-007 dmem_req  input  1  MEM-stage instruction accesses data memory this cycle.
REQ-008 dmem_ack  input  1  data memory completes the access this cycle.
REQ-009 pc_en, ifid_en, idex_en, exmem_en  output  1 each  pipeline register load enables.
REQ-010 ifid_flush, idex_flush, memwb_bubble  output  1 each  bubble/NOP insertion into IF/ID, ID/EX and MEM/WB.
REQ-011 mem_err  output  1  sticky data-memory timeout flag.
REQ-012 stall_cnt, flush_cnt  output  16 each  performance counters.
REQ-013 state  output  2  current FSM state: RUN=0, FLUSH=1, MEM_WAIT=2.

Function
REQ-014 The FSM SHALL have states RUN, FLUSH and MEM_WAIT; control outputs are combinational (Mealy) from state and inputs, and the response acts in the same cycle as the request.
REQ-015 Idle RUN (no requests): all enables 1, all flush/bubble outputs 0.
REQ-016 Priority in RUN: memory stall (dmem_req=1 & dmem_ack=0) > br_taken > nop_req.
REQ-017 Memory stall: pc_en=ifid_en=idex_en=exmem_en=0, memwb_bubble=1, br_taken and nop_req ignored, wait counter loaded to 1, next state MEM_WAIT.
REQ-018 br_taken: pc_en=1, ifid_flush=1, idex_flush=1, nop_req ignored, flush_cnt+1; next state FLUSH with flush counter = FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
REQ-019 nop_req alone: pc_en=0, ifid_en=0, idex_flush=1, idex_en=exmem_en=1; next state RUN.
REQ-020 MEM_WAIT with dmem_ack=0 and wait counter < TIMEOUT: freeze outputs as in REQ-017, wait counter +1.
REQ-021 MEM_WAIT with dmem_ack=1: the cycle behaves exactly as RUN without the memory-stall term, and the next state follows REQ-018/REQ-019 (RUN or FLUSH).
REQ-022 MEM_WAIT with dmem_ack=0 and wait counter = TIMEOUT: mem_err set to 1, the cycle is treated as dmem_ack=1 (REQ-021).
REQ-023 FLUSH: pc_en=1, ifid_flush=1, other enables 1; the flush counter decrements and the state returns to RUN when it reaches 0.
REQ-024 FLUSH with memory stall: freeze per REQ-017, flush counter holds, state stays FLUSH.
REQ-025 FLUSH with br_taken: outputs per REQ-018, flush_cnt+1, flush counter reloaded to FLUSH_CYCLES-1.
REQ-026 stall_cnt SHALL increment each cycle pc_en=0 while rst_n=1; it saturates at 16'hFFFF.
REQ-027 flush_cnt SHALL increment per accepted br_taken; it saturates at 16'hFFFF.
REQ-028 mem_err SHALL be cleared only by reset.

Reset
REQ-029 While rst_n=0: state=RUN, all internal counters 0, stall_cnt=flush_cnt=0, mem_err=0, all enables 0, ifid_flush=idex_flush=memwb_bubble=1, independent of clk.
REQ-030 Reset asserted in any state SHALL abort the operation immediately; the first cycle after release is idle RUN.

Verification
REQ-031 Bench: RUN, nop_req=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_cnt=1; next cycle idle outputs.
REQ-032 Bench: FLUSH_CYCLES=3, br_taken 1 cycle -> ifid_flush=1 for 3 cycles, idex_flush=1 in the first only; flush_cnt=1; state 1,1 then 0.
REQ-033 Bench: dmem_req=1, dmem_ack low 4 cycles then high, with nop_req=1 throughout -> 4 freeze cycles, then load-use stall on the ack cycle; stall_cnt=5.
REQ-034 Bench: TIMEOUT=8, dmem_req=1, dmem_ack never -> freeze 8 cycles, release on cycle 9, mem_err=1 sticky.
REQ-035 Bench: br_taken with simultaneous memory stall -> freeze, flush_cnt unchanged; flush applied in the ack cycle.
REQ-036 Bench: rst_n low mid-MEM_WAIT (asynchronous edge) -> outputs go to reset values immediately; counters 0; mem_err 0.
